// File: rtl/nand_cpu.sv
`default_nettype none
// ============================================================================
// Module      : nand_cpu_mem
// Description : 16-bit wide word memory with a combinational read port and a
//               synchronous write port sharing one address. Contents are held
//               in the unpacked array `core`, which has no reset, so program
//               and data images survive a core reset.
// Ports       : clk     - write clock
//               we_i    - write enable
//               addr_i  - word address (read and write)
//               wdata_i - write data
//               rdata_o - combinational read data
// Revision    : 1.0 - initial release
// ============================================================================
module nand_cpu_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [15:0]   wdata_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] core [0:DEPTH-1];

    assign rdata_o = core[addr_i];

    // Deliberately no reset: memory contents persist across core resets.
    always @(posedge clk) begin
        if (we_i) begin
            core[addr_i] <= wdata_i;
        end
    end

endmodule

// ============================================================================
// Module      : nand_cpu
// Description : Single-cycle 16-bit Harvard CPU with eight 16-bit registers,
//               an internal instruction memory (I_MEM) and data memory
//               (D_MEM). Runs from address 0 after reset and raises halt
//               once a HALT instruction has executed.
// Ports       : clk   - system clock, all state updates on the rising edge
//               n_rst - asynchronous active-low reset
//               halt  - high once HALT has executed, held until reset
// Revision    : 1.0 - initial release
// ============================================================================
module nand_cpu #(
    parameter int IMEM_DEPTH = 256,  // power of two; PC wraps modulo depth
    parameter int DMEM_DEPTH = 256   // power of two; address = low bits of rb
) (
    input  logic clk,
    input  logic n_rst,
    output logic halt
);

    localparam int PW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);

    localparam logic [3:0] c_OP_NAND = 4'h0;
    localparam logic [3:0] c_OP_ADD  = 4'h1;
    localparam logic [3:0] c_OP_LI   = 4'h2;
    localparam logic [3:0] c_OP_LUI  = 4'h3;
    localparam logic [3:0] c_OP_LD   = 4'h4;
    localparam logic [3:0] c_OP_ST   = 4'h5;
    localparam logic [3:0] c_OP_BZ   = 4'h6;
    localparam logic [3:0] c_OP_BNZ  = 4'h7;
    localparam logic [3:0] c_OP_SUB  = 4'h8;
    localparam logic [3:0] c_OP_HALT = 4'hF;

    // Architectural state
    logic [PW-1:0] pc_q;
    logic [PW-1:0] pc_d;
    logic [15:0]   regs_q [0:7];
    logic          halt_q;
    logic          halt_d;

    // Decode / datapath
    logic [15:0]   w_instr;
    logic [3:0]    w_op;
    logic [2:0]    w_ra;
    logic [2:0]    w_rb;
    logic [2:0]    w_rc;
    logic [7:0]    w_imm8;
    logic [15:0]   w_sext;
    logic [15:0]   w_ra_val;
    logic [15:0]   w_rb_val;
    logic [15:0]   w_rc_val;
    logic [15:0]   w_dmem_rdata;
    logic [PW-1:0] w_pc_seq;
    logic [15:0]   w_br_full;
    logic [PW-1:0] w_pc_br;
    logic          w_reg_we;
    logic [15:0]   w_reg_wdata;
    logic          w_dmem_we;
    logic          w_dmem_we_gated;

    nand_cpu_mem #(
        .DEPTH (IMEM_DEPTH),
        .AW    (PW)
    ) I_MEM (
        .clk     (clk),
        .we_i    (1'b0),        // the core never writes its own program
        .addr_i  (pc_q),
        .wdata_i (16'h0000),
        .rdata_o (w_instr)
    );

    nand_cpu_mem #(
        .DEPTH (DMEM_DEPTH),
        .AW    (DW)
    ) D_MEM (
        .clk     (clk),
        .we_i    (w_dmem_we_gated),
        .addr_i  (w_rb_val[DW-1:0]),
        .wdata_i (w_ra_val),
        .rdata_o (w_dmem_rdata)
    );

    assign w_op     = w_instr[15:12];
    assign w_ra     = w_instr[11:9];
    assign w_rb     = w_instr[8:6];
    assign w_rc     = w_instr[5:3];
    assign w_imm8   = w_instr[7:0];
    assign w_sext   = {{8{w_imm8[7]}}, w_imm8};

    assign w_ra_val = regs_q[w_ra];
    assign w_rb_val = regs_q[w_rb];
    assign w_rc_val = regs_q[w_rc];

    assign w_pc_seq  = pc_q + PW'(1);
    // Branch target is computed at full width then truncated, giving the
    // modulo-IMEM_DEPTH wrap in both directions.
    assign w_br_full = 16'(pc_q) + 16'd1 + w_sext;
    assign w_pc_br   = w_br_full[PW-1:0];

    // The memory write is not on the async reset path, so a store that would
    // land on an edge while reset is held is blocked here instead.
    assign w_dmem_we_gated = w_dmem_we & n_rst;

    always_comb begin
        pc_d        = w_pc_seq;
        halt_d      = halt_q;
        w_reg_we    = 1'b0;
        w_reg_wdata = 16'h0000;
        w_dmem_we   = 1'b0;
        if (halt_q) begin
            pc_d = pc_q;
        end else begin
            case (w_op)
                c_OP_NAND: begin
                    w_reg_we    = 1'b1;
                    w_reg_wdata = ~(w_rb_val & w_rc_val);
                end
                c_OP_ADD: begin
                    w_reg_we    = 1'b1;
                    w_reg_wdata = w_rb_val + w_rc_val;
                end
                c_OP_LI: begin
                    w_reg_we    = 1'b1;
                    w_reg_wdata = w_sext;
                end
                c_OP_LUI: begin
                    w_reg_we    = 1'b1;
                    w_reg_wdata = {w_imm8, w_ra_val[7:0]};
                end
                c_OP_LD: begin
                    w_reg_we    = 1'b1;
                    w_reg_wdata = w_dmem_rdata;
                end
                c_OP_ST: begin
                    w_dmem_we = 1'b1;
                end
                c_OP_BZ: begin
                    if (w_ra_val == 16'h0000) begin
                        pc_d = w_pc_br;
                    end
                end
                c_OP_BNZ: begin
                    if (w_ra_val != 16'h0000) begin
                        pc_d = w_pc_br;
                    end
                end
                c_OP_SUB: begin
                    w_reg_we    = 1'b1;
                    w_reg_wdata = w_rb_val - w_rc_val;
                end
                c_OP_HALT: begin
                    halt_d = 1'b1;
                    pc_d   = pc_q;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pc_q   <= '0;
            halt_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else begin
            pc_q   <= pc_d;
            halt_q <= halt_d;
            if (w_reg_we) begin
                regs_q[w_ra] <= w_reg_wdata;
            end
        end
    end

    assign halt = halt_q;

endmodule
`default_nettype wire

// File: tb/tb_nand_cpu.sv
`default_nettype none
// ============================================================================
// Module      : tb_nand_cpu
// Description : Self-checking bench for nand_cpu. Directed programs check
//               fixed results; random programs are compared against an
//               instruction-level model of the architecture.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nand_cpu;

    localparam int IMEM_DEPTH = 256;
    localparam int DMEM_DEPTH = 256;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    logic halt;

    int checks = 0;
    int errors = 0;

    nand_cpu #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .DMEM_DEPTH (DMEM_DEPTH)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .halt  (halt)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Instruction-level reference model
    // ------------------------------------------------------------------
    logic [15:0] m_imem [0:IMEM_DEPTH-1];
    logic [15:0] m_dmem [0:DMEM_DEPTH-1];
    logic [15:0] m_reg  [0:7];
    int          m_pc;
    bit          m_halt;

    function automatic void model_reset();
        m_pc   = 0;
        m_halt = 1'b0;
        for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
    endfunction

    function automatic void model_step();
        logic [15:0] ins;
        int op, ra, rb, rc, imm, npc;
        if (m_halt) return;
        ins = m_imem[m_pc];
        op  = int'(ins[15:12]);
        ra  = int'(ins[11:9]);
        rb  = int'(ins[8:6]);
        rc  = int'(ins[5:3]);
        imm = int'($signed(ins[7:0]));
        npc = (m_pc + 1) % IMEM_DEPTH;
        case (op)
            0:  m_reg[ra] = ~(m_reg[rb] & m_reg[rc]);
            1:  m_reg[ra] = m_reg[rb] + m_reg[rc];
            2:  m_reg[ra] = 16'(imm);
            3:  m_reg[ra] = {ins[7:0], m_reg[ra][7:0]};
            4:  m_reg[ra] = m_dmem[int'(m_reg[rb]) % DMEM_DEPTH];
            5:  m_dmem[int'(m_reg[rb]) % DMEM_DEPTH] = m_reg[ra];
            6:  if (m_reg[ra] == 16'h0000)
                    npc = ((m_pc + 1 + imm) % IMEM_DEPTH + IMEM_DEPTH) % IMEM_DEPTH;
            7:  if (m_reg[ra] != 16'h0000)
                    npc = ((m_pc + 1 + imm) % IMEM_DEPTH + IMEM_DEPTH) % IMEM_DEPTH;
            8:  m_reg[ra] = m_reg[rb] - m_reg[rc];
            15: begin m_halt = 1'b1; npc = m_pc; end
            default: ;
        endcase
        m_pc = npc;
    endfunction

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [15:0] enc_r(input int op, input int ra, input int rb, input int rc);
        return 16'((op << 12) | (ra << 9) | (rb << 6) | (rc << 3));
    endfunction

    function automatic logic [15:0] enc_i(input int op, input int ra, input int imm);
        return 16'((op << 12) | (ra << 9) | (imm & 8'hFF));
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < IMEM_DEPTH; i++) m_imem[i] = 16'hF000;
    endtask

    task automatic load_prog();
        for (int i = 0; i < IMEM_DEPTH; i++) dut.I_MEM.core[i] = m_imem[i];
    endtask

    task automatic dm_poke(input int addr, input logic [15:0] val);
        m_dmem[addr]            = val;
        dut.D_MEM.core[addr]    = val;
    endtask

    // 40 ns reset pulse; halt and PC are sampled while it is held. D_MEM[0]
    // is written in the same timestep as the release.
    task automatic do_reset(input logic [15:0] d0);
        @(negedge clk);
        n_rst = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #2;
            check("rst_halt", 16'(halt), 16'h0000);
            check("rst_pc", 16'(dut.pc_q), 16'h0000);
        end
        @(negedge clk);
        n_rst = 1'b1;
        dm_poke(0, d0);
        model_reset();
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            model_step();
        end
    endtask

    task automatic wait_halt(input int budget);
        for (int c = 0; c < budget && !halt; c++) run_cycles(1);
    endtask

    task automatic compare_state(input string tag);
        check({tag, "_pc"}, 16'(dut.pc_q), 16'(m_pc));
        check({tag, "_halt"}, 16'(halt), 16'(m_halt));
        for (int r = 0; r < 8; r++)
            check($sformatf("%s_r%0d", tag, r), dut.regs_q[r], m_reg[r]);
    endtask

    task automatic load_count_to();
        clear_prog();
        m_imem[0] = enc_r(4'h4, 1, 0, 0);   // LD  r1,[r0]     N
        m_imem[1] = enc_i(4'h2, 3, 1);      // LI  r3,1
        m_imem[2] = enc_i(4'h2, 2, 0);      // LI  r2,0        i
        m_imem[3] = enc_i(4'h6, 1, 4);      // BZ  r1,+4 -> 8
        m_imem[4] = enc_r(4'h1, 2, 2, 3);   // ADD r2,r2,r3
        m_imem[5] = enc_r(4'h5, 2, 2, 0);   // ST  r2,[r2]
        m_imem[6] = enc_r(4'h8, 1, 1, 3);   // SUB r1,r1,r3
        m_imem[7] = enc_i(4'h7, 1, -4);     // BNZ r1,-4 -> 4
        m_imem[8] = 16'hF000;               // HALT
        load_prog();
    endtask

    function automatic logic [15:0] rand_instr();
        int sel;
        logic [3:0] op;
        sel = int'($urandom_range(0, 99));
        if (sel < 4)       op = 4'hF;
        else if (sel < 10) op = 4'($urandom_range(9, 14));
        else               op = 4'($urandom_range(0, 8));
        return {op, 12'($urandom)};
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        for (int a = 0; a < DMEM_DEPTH; a++) dm_poke(a, 16'h0000);

        // NAND program: D_MEM[0] = ~(0x000F & 0x0033), halt after 5 cycles
        clear_prog();
        m_imem[0] = enc_i(4'h2, 1, 8'h0F);
        m_imem[1] = enc_i(4'h2, 2, 8'h33);
        m_imem[2] = enc_r(4'h0, 3, 1, 2);
        m_imem[3] = enc_r(4'h5, 3, 0, 0);
        m_imem[4] = 16'hF000;
        load_prog();
        do_reset(16'h5A5A);
        run_cycles(4);
        check("nand_halt_4", 16'(halt), 16'h0000);
        run_cycles(1);
        check("nand_halt_5", 16'(halt), 16'h0001);
        check("nand_dmem0", dut.D_MEM.core[0], 16'hFFFC);
        check("nand_pc", 16'(dut.pc_q), 16'h0004);

        // Branch program: BZ taken skips the first HALT
        clear_prog();
        m_imem[0] = enc_i(4'h2, 1, -1);
        m_imem[1] = enc_i(4'h2, 2, 1);
        m_imem[2] = enc_r(4'h1, 3, 1, 2);
        m_imem[3] = enc_i(4'h6, 3, 1);
        m_imem[4] = 16'hF000;
        m_imem[5] = enc_r(4'h5, 1, 2, 0);
        m_imem[6] = 16'hF000;
        load_prog();
        dm_poke(1, 16'h0000);
        do_reset(16'h1111);
        run_cycles(6);
        check("br_halt", 16'(halt), 16'h0001);
        check("br_pc", 16'(dut.pc_q), 16'h0006);
        check("br_dmem1", dut.D_MEM.core[1], 16'hFFFF);

        // Frozen after halt for 20 more clocks
        run_cycles(20);
        check("frz_halt", 16'(halt), 16'h0001);
        check("frz_pc", 16'(dut.pc_q), 16'h0006);
        check("frz_dmem0", dut.D_MEM.core[0], 16'h1111);
        check("frz_dmem1", dut.D_MEM.core[1], 16'hFFFF);
        check("frz_r3", dut.regs_q[3], 16'h0000);

        // Store blocked on an edge where reset is held
        clear_prog();
        m_imem[0] = enc_i(4'h2, 1, 8'h55);
        m_imem[1] = enc_r(4'h5, 1, 0, 0);
        m_imem[2] = 16'hF000;
        load_prog();
        do_reset(16'h1234);
        run_cycles(1);
        n_rst = 1'b0;
        #1;
        check("async_pc", 16'(dut.pc_q), 16'h0000);
        check("async_r1", dut.regs_q[1], 16'h0000);
        @(posedge clk);
        #2;
        check("blk_dmem0", dut.D_MEM.core[0], 16'h1234);
        do_reset(16'h1234);
        wait_halt(20);
        check("blk_halt", 16'(halt), 16'h0001);
        check("blk_dmem0_after", dut.D_MEM.core[0], 16'h0055);

        // count_to for N = 0..9
        load_count_to();
        for (int n = 0; n <= 9; n++) begin
            for (int i = 1; i <= 9; i++) dm_poke(i, 16'hDEAD);
            do_reset(16'(n));
            wait_halt(300);
            check($sformatf("cnt%0d_halt", n), 16'(halt), 16'h0001);
            for (int i = 1; i <= 9; i++)
                check($sformatf("cnt%0d_d%0d", n, i), dut.D_MEM.core[i],
                      (i <= n) ? 16'(i) : 16'hDEAD);
        end
        run_cycles(20);
        check("cnt_frz_halt", 16'(halt), 16'h0001);
        check("cnt_frz_d9", dut.D_MEM.core[9], 16'h0009);

        // Reset pulsed in the middle of the store loop, then a clean rerun
        for (int i = 1; i <= 9; i++) dm_poke(i, 16'hDEAD);
        do_reset(16'h0009);
        run_cycles(15);
        n_rst = 1'b0;
        #1;
        check("mid_halt", 16'(halt), 16'h0000);
        check("mid_pc", 16'(dut.pc_q), 16'h0000);
        check("mid_r2", dut.regs_q[2], 16'h0000);
        do_reset(16'h0009);
        wait_halt(300);
        check("mid_rerun_halt", 16'(halt), 16'h0001);
        for (int i = 1; i <= 9; i++)
            check($sformatf("mid_d%0d", i), dut.D_MEM.core[i], 16'(i));

        // Random programs against the model
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < IMEM_DEPTH; i++) m_imem[i] = rand_instr();
            load_prog();
            for (int a = 0; a < DMEM_DEPTH; a++) dm_poke(a, 16'($urandom));
            do_reset(16'($urandom));
            for (int seg = 0; seg < 4; seg++) begin
                run_cycles(25);
                compare_state($sformatf("rnd%0d_s%0d", p, seg));
            end
            for (int a = 0; a < DMEM_DEPTH; a++)
                check($sformatf("rnd%0d_d%0d", p, a), dut.D_MEM.core[a], m_dmem[a]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
